// File: rtl/m_p_to_s.sv
// Parallel-to-serial transmitter: captures a WORD-bit word on start and shifts it out MSB first,
// then spends one cycle in DONE, where a new start is accepted so words can run back-to-back.
module m_p_to_s #(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD-1:0] parallel_d,
    output logic            serial_d,
    output logic            serial_valid,
    output logic            busy,
    output logic            done,
    // Debug view of the FSM: 0 = IDLE, 1 = SHIFT, 2 = DONE
    output logic [1:0]      state_dbg
);

    localparam int CW = ($clog2(WORD) < 1) ? 1 : $clog2(WORD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WORD-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    // Outputs are decoded from the registers alone, so an asynchronous reset
    // clears them immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        cnt_nxt      = cnt;
        serial_d     = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt = S_SHIFT;
                    shift_nxt = parallel_d;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                serial_d     = shift_reg[WORD-1];
                serial_valid = 1'b1;
                busy         = 1'b1;
                shift_nxt    = {shift_reg[WORD-2:0], 1'b0};
                // Hold the counter on the final bit so it never wraps within a word.
                if (cnt == CW'(WORD - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_m_p_to_s.sv
// Bench for m_p_to_s: a per-cycle schedule model for WORD=8 and WORD=4 instances, a loopback
// receiver for the 8-bit instance, and directed scenarios with hand-computed expectations.
module tb_m_p_to_s;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       start4 = 1'b0;
    logic [3:0] d4 = 4'h0;
    logic       sd8, v8, b8, dn8;
    logic       sd4, v4, b4, dn4;
    logic [1:0] st8, st4;

    int n_tests = 0;
    int n_fail  = 0;

    m_p_to_s #(.WORD(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .parallel_d(d8),
        .serial_d(sd8), .serial_valid(v8), .busy(b8), .done(dn8), .state_dbg(st8)
    );

    m_p_to_s #(.WORD(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .parallel_d(d4),
        .serial_d(sd4), .serial_valid(v4), .busy(b4), .done(dn4), .state_dbg(st4)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Each queue entry is the expected {serial_d, serial_valid, busy, done} of one future cycle;
    // an empty queue means the idle output (all zero).
    logic [3:0] exp8_q[$];
    logic [3:0] exp4_q[$];
    logic [7:0] sent8_q[$];
    logic [3:0] cur8, cur4;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp8_q.delete();
            exp4_q.delete();
            sent8_q.delete();
        end else begin
            cur8 = (exp8_q.size() > 0) ? exp8_q.pop_front() : 4'b0000;
            cur4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 4'b0000;
            // A start is honoured whenever no payload bit is on the line this cycle.
            if (start8 && !cur8[2]) begin
                for (int k = 7; k >= 0; k--) exp8_q.push_back({d8[k], 3'b110});
                exp8_q.push_back(4'b0001);
                sent8_q.push_back(d8);
            end
            if (start4 && !cur4[2]) begin
                for (int k = 3; k >= 0; k--) exp4_q.push_back({d4[k], 3'b110});
                exp4_q.push_back(4'b0001);
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [7:0] rx8 = 8'h00;
    logic [7:0] lb_exp;

    always @(negedge clk) begin
        check("cyc8", {28'd0, sd8, v8, b8, dn8}, {28'd0, (exp8_q.size() > 0) ? exp8_q[0] : 4'b0000});
        check("cyc4", {28'd0, sd4, v4, b4, dn4}, {28'd0, (exp4_q.size() > 0) ? exp4_q[0] : 4'b0000});
        // Receiver side of the loopback: shifts {word[6:0], serial_d} on every valid bit.
        if (v8) rx8 = {rx8[6:0], sd8};
        if (dn8 && sent8_q.size() > 0) begin
            lb_exp = sent8_q.pop_front();
            check("loopback", {24'd0, rx8}, {24'd0, lb_exp});
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse8(input logic [7:0] v);
        @(negedge clk);
        d8 = v;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        d8 = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse4(input logic [3:0] v);
        @(negedge clk);
        d4 = v;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        d4 = 4'($urandom_range(0, 15));
    endtask

    // Observes ncyc cycles after a capture edge (cycle 1 = first cycle after it).
    task automatic capture(input bit sel, input int ncyc, output logic [31:0] bits,
                           output int nvalid, output int done1, output int done2, output int gaps);
        logic o_sd, o_v, o_d;
        int lows;
        bits = '0; nvalid = 0; done1 = 0; done2 = 0; gaps = 0; lows = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            o_sd = sel ? sd4 : sd8;
            o_v  = sel ? v4  : v8;
            o_d  = sel ? dn4 : dn8;
            if (o_v) begin
                bits = {bits[30:0], o_sd};
                nvalid++;
                gaps += lows;
                lows = 0;
            end else if (nvalid > 0) begin
                lows++;
            end
            if (o_d) begin
                if (done1 == 0) done1 = c;
                else if (done2 == 0) done2 = c;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    logic [31:0] bits;
    int nv, dc1, dc2, gp;
    logic [7:0] pats[2] = '{8'h00, 8'hFF};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out8", {28'd0, sd8, v8, b8, dn8}, 32'd0);
        check("rst_out4", {28'd0, sd4, v4, b4, dn4}, 32'd0);
        check("rst_state8", {30'd0, st8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // A5 single word
        pulse8(8'hA5);
        check("model_len", exp8_q.size(), 32'd9);
        check("model_first", {28'd0, exp8_q[0]}, 32'hE);
        check("shift_state8", {30'd0, st8}, 32'd1);
        capture(1'b0, 12, bits, nv, dc1, dc2, gp);
        check("a5_bits", bits, 32'hA5);
        check("a5_nvalid", nv, 32'd8);
        check("a5_done", dc1, 32'd9);
        check("a5_done2", dc2, 32'd0);

        // start held high: 3C then C3 back-to-back
        @(negedge clk);
        d8 = 8'h3C;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        d8 = 8'hC3;
        fork
            begin
                repeat (9) @(posedge clk);
                #1;
                start8 = 1'b0;
            end
            capture(1'b0, 22, bits, nv, dc1, dc2, gp);
        join
        check("b2b_bits", bits, 32'h3CC3);
        check("b2b_nvalid", nv, 32'd16);
        check("b2b_gap", gp, 32'd1);
        check("b2b_done1", dc1, 32'd9);
        check("b2b_done2", dc2, 32'd18);

        // start during SHIFT is ignored
        pulse8(8'hF0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                d8 = 8'h0F;
                start8 = 1'b1;
                @(posedge clk);
                #1;
                start8 = 1'b0;
            end
            capture(1'b0, 14, bits, nv, dc1, dc2, gp);
        join
        check("ign_bits", bits, 32'hF0);
        check("ign_nvalid", nv, 32'd8);
        check("ign_done", dc1, 32'd9);
        check("ign_done2", dc2, 32'd0);

        // asynchronous reset during bit 3 of FF
        pulse8(8'hFF);
        repeat (3) @(posedge clk);
        #3;
        check("abort_bit3", {31'd0, sd8}, 32'd1);
        reset = 1'b1;
        d8 = 8'hFF;
        start8 = 1'b1;
        #1;
        check("abort_async", {28'd0, sd8, v8, b8, dn8}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_hold", {28'd0, sd8, v8, b8, dn8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d8 = 8'h81;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        capture(1'b0, 12, bits, nv, dc1, dc2, gp);
        check("post_rst_bits", bits, 32'h81);
        check("post_rst_done", dc1, 32'd9);

        // all-zero and all-one words
        for (int i = 0; i < 2; i++) begin
            pulse8(pats[i]);
            capture(1'b0, 10, bits, nv, dc1, dc2, gp);
            check("edge_bits", bits, {24'd0, pats[i]});
            check("edge_nvalid", nv, 32'd8);
            check("edge_done", dc1, 32'd9);
        end

        // WORD=4 instance
        pulse4(4'b1001);
        capture(1'b1, 7, bits, nv, dc1, dc2, gp);
        check("w4_bits", bits, 32'h9);
        check("w4_nvalid", nv, 32'd4);
        check("w4_done", dc1, 32'd5);

        // loopback: 256 random words
        for (int i = 0; i < 256; i++) begin
            pulse8(8'($urandom_range(0, 255)));
            repeat (10) @(negedge clk);
        end
        check("lb_drained", sent8_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
